int_alu_exec_stage: RTL and testbench
=====================================

Name: int_alu_exec_stage

Overview:
Integer ALU execute stage, directly downstream of the integer reservation station. It accepts one issued uop per cycle through a valid/ready handshake, together with the operand values read from the PRF in the issue cycle. The uop passes through a two-entry pipeline: X (operand register) and W (result register). The W register drives one CDB port and a same-cycle bypass tap. Backpressure from CDB arbitration propagates back to the RS through in_ready.

Parameters:
ROB_IDX, 5, ROB id width
PRF_IDX, 6, physical register index width
ARF_IDX, 5, architectural register index width
XLEN, 32, datapath width

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  RS has an issued uop
in_ready  out  1  stage accepts the uop this cycle
in_rob_id  in  ROB_IDX  ROB tag
in_rd_phy  in  PRF_IDX  destination physical register
in_rd_arch  in  ARF_IDX  destination architectural register
in_op1_sel  in  1  0=rs1_value, 1=pc
in_op2_sel  in  1  0=rs2_value, 1=imm
in_fu_opcode  in  4  ALU operation
in_imm  in  XLEN  immediate
in_pc  in  XLEN  uop pc
in_rs1_value  in  XLEN  PRF read data, rs1
in_rs2_value  in  XLEN  PRF read data, rs2
cdb_valid  out  1  W holds a result
cdb_ready  in  1  CDB grant
cdb_rob_id  out  ROB_IDX  result tag
cdb_rd_phy  out  PRF_IDX  result physical register
cdb_rd_arch  out  ARF_IDX  result architectural register
cdb_rd_value  out  XLEN  result value
bypass_valid  out  1  bypass tap valid
bypass_rd_phy  out  PRF_IDX  bypass destination
bypass_value  out  XLEN  bypass value

Behaviour:
- Reset: rst is synchronous and active-high. On reset, x_valid=0 and w_valid=0, so cdb_valid=0, bypass_valid=0 and in_ready=1. Payload registers are don't-care.
- Transfer rule: a uop transfers when in_valid && in_ready. All in_* fields, including the rs values, are latched into X at that edge; the PRF is not re-read later.
- W drains when w_valid && cdb_ready. W is free when !w_valid || drain.
- X advances into W when x_valid && W free. The ALU result is computed combinationally from X and written into W.
- in_ready = !x_valid || x_advance. It is purely combinational and has no dependence on in_valid.
- Latency: a transfer at edge E puts the uop in X for the following cycle. cdb_valid is asserted in the cycle after that, provided W was free.
- Throughput: 1 uop/cycle while cdb_ready is held 1.
- Stall: while cdb_valid=1 and cdb_ready=0, W holds and all cdb_* outputs stay stable. X fills, then in_ready drops to 0. No uop is lost or duplicated.
- Simultaneous events: in the same cycle, W drains, X moves into W and a new uop enters X.
- Operand selection: opA = op1_sel ? pc : rs1. opB = op2_sel ? imm : rs2.
- Opcodes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB (result = opB).
  - Shift amount is opB[4:0]. SLT and SLTU return a 0/1 result zero-extended to XLEN.
  - Opcodes 11–15: result = 0, with an assertion fired on entry to W.
- Arithmetic wraps modulo 2^XLEN; no overflow flag.
- rd_arch == 0: the result is still broadcast so the ROB completes the uop, but cdb_rd_value is forced to 0 and bypass_valid=0.
- Bypass: bypass_valid = w_valid && rd_arch != 0. bypass_rd_phy and bypass_value mirror W. The tap stays valid for the whole stall.
- Reset mid-operation: X and W are invalidated on the next edge regardless of cdb_ready. in_ready=1 on the following cycle.

Test Plan:
1. Reset held 2 cycles, then released → cdb_valid=0, bypass_valid=0, in_ready=1.
2. ADD issued: rs1=5, rs2=7, rob_id=3, rd_phy=9, rd_arch=1, cdb_ready=1 → 2 cycles after transfer: cdb_valid=1, value 12, rob_id 3, rd_phy 9; bypass_valid=1, bypass_value 12.
3. Back-to-back uops with cdb_ready=1:
   - SUB 3−5 → 0xFFFFFFFE.
   - SRA 0x80000000 by imm 4 → 0xF8000000.
   - SLTU 1 vs 0xFFFFFFFF → 1.
   - Results appear on 3 consecutive cycles, in order.
4. cdb_ready=0 for 4 cycles while 3 uops are offered → W holds, in_ready=0 once X is full, only 2 uops accepted. After cdb_ready=1, results drain in order with no loss.
5. PASSB with imm=0xABCD0000 and rd_arch=0 → cdb_valid=1, cdb_rd_value=0, bypass_valid=0.
6. Assert rst while X and W are both valid and cdb_ready=0 → next cycle cdb_valid=0, in_ready=1; no stale result is broadcast.

Source files
------------

// File: rtl/int_alu_exec_stage.sv
// Integer ALU execute stage: X (operands) -> ALU -> W (result) feeding one CDB port plus a bypass tap.
// Latency: issue edge -> cdb_valid two cycles later; a CDB stall holds W, then X, then drops in_ready.
module int_alu_exec_stage #(
  parameter int ROB_IDX = 5,
  parameter int PRF_IDX = 6,
  parameter int ARF_IDX = 5,
  parameter int XLEN    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ROB_IDX-1:0] in_rob_id,
  input  logic [PRF_IDX-1:0] in_rd_phy,
  input  logic [ARF_IDX-1:0] in_rd_arch,
  input  logic               in_op1_sel,
  input  logic               in_op2_sel,
  input  logic [3:0]         in_fu_opcode,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [XLEN-1:0]    in_rs1_value,
  input  logic [XLEN-1:0]    in_rs2_value,
  output logic               cdb_valid,
  input  logic               cdb_ready,
  output logic [ROB_IDX-1:0] cdb_rob_id,
  output logic [PRF_IDX-1:0] cdb_rd_phy,
  output logic [ARF_IDX-1:0] cdb_rd_arch,
  output logic [XLEN-1:0]    cdb_rd_value,
  output logic               bypass_valid,
  output logic [PRF_IDX-1:0] bypass_rd_phy,
  output logic [XLEN-1:0]    bypass_value
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;

  // X stage
  logic               x_valid_q,    x_valid_d;
  logic [ROB_IDX-1:0] x_rob_id_q,   x_rob_id_d;
  logic [PRF_IDX-1:0] x_rd_phy_q,   x_rd_phy_d;
  logic [ARF_IDX-1:0] x_rd_arch_q,  x_rd_arch_d;
  logic               x_op1_sel_q,  x_op1_sel_d;
  logic               x_op2_sel_q,  x_op2_sel_d;
  logic [3:0]         x_opcode_q,   x_opcode_d;
  logic [XLEN-1:0]    x_imm_q,      x_imm_d;
  logic [XLEN-1:0]    x_pc_q,       x_pc_d;
  logic [XLEN-1:0]    x_rs1_q,      x_rs1_d;
  logic [XLEN-1:0]    x_rs2_q,      x_rs2_d;

  // W stage
  logic               w_valid_q,    w_valid_d;
  logic [ROB_IDX-1:0] w_rob_id_q,   w_rob_id_d;
  logic [PRF_IDX-1:0] w_rd_phy_q,   w_rd_phy_d;
  logic [ARF_IDX-1:0] w_rd_arch_q,  w_rd_arch_d;
  logic [XLEN-1:0]    w_value_q,    w_value_d;

  logic            w_drain;
  logic            w_free;
  logic            x_advance;
  logic            x_load;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res;

  always_comb begin
    w_drain   = w_valid_q && cdb_ready;
    w_free    = !w_valid_q || w_drain;
    x_advance = x_valid_q && w_free;
    in_ready  = !x_valid_q || x_advance;
    x_load    = in_valid && in_ready;
  end

  always_comb begin
    op_a    = x_op1_sel_q ? x_pc_q  : x_rs1_q;
    op_b    = x_op2_sel_q ? x_imm_q : x_rs2_q;
    shamt   = op_b[4:0];
    alu_res = '0;
    case (x_opcode_q)
      OP_ADD:   alu_res = op_a + op_b;
      OP_SUB:   alu_res = op_a - op_b;
      OP_SLL:   alu_res = op_a << shamt;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_XOR:   alu_res = op_a ^ op_b;
      OP_SRL:   alu_res = op_a >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
      OP_OR:    alu_res = op_a | op_b;
      OP_AND:   alu_res = op_a & op_b;
      OP_PASSB: alu_res = op_b;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    x_valid_d   = x_valid_q;
    x_rob_id_d  = x_rob_id_q;
    x_rd_phy_d  = x_rd_phy_q;
    x_rd_arch_d = x_rd_arch_q;
    x_op1_sel_d = x_op1_sel_q;
    x_op2_sel_d = x_op2_sel_q;
    x_opcode_d  = x_opcode_q;
    x_imm_d     = x_imm_q;
    x_pc_d      = x_pc_q;
    x_rs1_d     = x_rs1_q;
    x_rs2_d     = x_rs2_q;
    w_valid_d   = w_valid_q;
    w_rob_id_d  = w_rob_id_q;
    w_rd_phy_d  = w_rd_phy_q;
    w_rd_arch_d = w_rd_arch_q;
    w_value_d   = w_value_q;

    if (x_advance) begin
      w_rob_id_d  = x_rob_id_q;
      w_rd_phy_d  = x_rd_phy_q;
      w_rd_arch_d = x_rd_arch_q;
      w_value_d   = alu_res;
    end
    if (x_advance)    w_valid_d = 1'b1;
    else if (w_drain) w_valid_d = 1'b0;

    // Operands are captured here once; the PRF is never re-read.
    if (x_load) begin
      x_rob_id_d  = in_rob_id;
      x_rd_phy_d  = in_rd_phy;
      x_rd_arch_d = in_rd_arch;
      x_op1_sel_d = in_op1_sel;
      x_op2_sel_d = in_op2_sel;
      x_opcode_d  = in_fu_opcode;
      x_imm_d     = in_imm;
      x_pc_d      = in_pc;
      x_rs1_d     = in_rs1_value;
      x_rs2_d     = in_rs2_value;
    end
    if (x_load)         x_valid_d = 1'b1;
    else if (x_advance) x_valid_d = 1'b0;

    if (rst) begin
      x_valid_d = 1'b0;
      w_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    x_valid_q   <= x_valid_d;
    x_rob_id_q  <= x_rob_id_d;
    x_rd_phy_q  <= x_rd_phy_d;
    x_rd_arch_q <= x_rd_arch_d;
    x_op1_sel_q <= x_op1_sel_d;
    x_op2_sel_q <= x_op2_sel_d;
    x_opcode_q  <= x_opcode_d;
    x_imm_q     <= x_imm_d;
    x_pc_q      <= x_pc_d;
    x_rs1_q     <= x_rs1_d;
    x_rs2_q     <= x_rs2_d;
    w_valid_q   <= w_valid_d;
    w_rob_id_q  <= w_rob_id_d;
    w_rd_phy_q  <= w_rd_phy_d;
    w_rd_arch_q <= w_rd_arch_d;
    w_value_q   <= w_value_d;
  end

  // Opcodes above PASSB are illegal; they still retire with a zero result.
  a_legal_opcode: assert property (@(posedge clk) disable iff (rst)
    x_advance |-> (x_opcode_q <= OP_PASSB));

  // x0 writes still complete in the ROB but must never carry data.
  always_comb begin
    cdb_valid     = w_valid_q;
    cdb_rob_id    = w_rob_id_q;
    cdb_rd_phy    = w_rd_phy_q;
    cdb_rd_arch   = w_rd_arch_q;
    cdb_rd_value  = (w_rd_arch_q == '0) ? '0 : w_value_q;
    bypass_valid  = w_valid_q && (w_rd_arch_q != '0);
    bypass_rd_phy = w_rd_phy_q;
    bypass_value  = w_value_q;
  end

endmodule

// File: tb/tb_int_alu_exec_stage.sv
// Randomized and directed bench for int_alu_exec_stage against an in-flight queue model.
module tb_int_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rob_id;
  logic [5:0]  in_rd_phy;
  logic [4:0]  in_rd_arch;
  logic        in_op1_sel;
  logic        in_op2_sel;
  logic [3:0]  in_fu_opcode;
  logic [31:0] in_imm;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_value;
  logic [31:0] in_rs2_value;
  logic        cdb_valid;
  logic        cdb_ready;
  logic [4:0]  cdb_rob_id;
  logic [5:0]  cdb_rd_phy;
  logic [4:0]  cdb_rd_arch;
  logic [31:0] cdb_rd_value;
  logic        bypass_valid;
  logic [5:0]  bypass_rd_phy;
  logic [31:0] bypass_value;

  always #5 clk = ~clk;

  int_alu_exec_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rob_id(in_rob_id), .in_rd_phy(in_rd_phy), .in_rd_arch(in_rd_arch),
    .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel), .in_fu_opcode(in_fu_opcode),
    .in_imm(in_imm), .in_pc(in_pc), .in_rs1_value(in_rs1_value), .in_rs2_value(in_rs2_value),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
    .cdb_rob_id(cdb_rob_id), .cdb_rd_phy(cdb_rd_phy), .cdb_rd_arch(cdb_rd_arch),
    .cdb_rd_value(cdb_rd_value),
    .bypass_valid(bypass_valid), .bypass_rd_phy(bypass_rd_phy), .bypass_value(bypass_value)
  );

  typedef struct {
    int          t;
    logic [4:0]  rob;
    logic [5:0]  phy;
    logic [4:0]  arch;
    logic [31:0] val;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] seen_val[$];
  int          seen_cyc[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << b[4:0];
      4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> b[4:0];
      4'd7:  return 32'($signed(a) >>> b[4:0]);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: in-flight uops in order; the oldest sits in W unless it entered X this very cycle.
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
    end else begin
      int  n;
      logic exp_rdy, exp_v;
      ent_t e;
      n       = mq.size();
      exp_rdy = (n < 2) || cdb_ready;
      exp_v   = (n == 2) || (n == 1 && cyc > mq[0].t);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("cdb_valid", 32'(cdb_valid), 32'(exp_v));
      if (exp_v) begin
        chk("cdb_rob_id", 32'(cdb_rob_id), 32'(mq[0].rob));
        chk("cdb_rd_phy", 32'(cdb_rd_phy), 32'(mq[0].phy));
        chk("cdb_rd_arch", 32'(cdb_rd_arch), 32'(mq[0].arch));
        chk("cdb_rd_value", cdb_rd_value, (mq[0].arch == 0) ? 32'd0 : mq[0].val);
        chk("bypass_valid", 32'(bypass_valid), 32'(mq[0].arch != 0));
        if (mq[0].arch != 0) begin
          chk("bypass_rd_phy", 32'(bypass_rd_phy), 32'(mq[0].phy));
          chk("bypass_value", bypass_value, mq[0].val);
        end
      end else begin
        chk("bypass_idle", 32'(bypass_valid), 32'd0);
      end
      if (cdb_valid && cdb_ready) begin
        seen_val.push_back(cdb_rd_value);
        seen_cyc.push_back(cyc);
      end
      if (exp_v && cdb_ready) void'(mq.pop_front());
      if (in_valid && exp_rdy) begin
        e.t    = cyc + 1;
        e.rob  = in_rob_id;
        e.phy  = in_rd_phy;
        e.arch = in_rd_arch;
        e.val  = ref_alu(in_fu_opcode, in_op1_sel ? in_pc : in_rs1_value,
                         in_op2_sel ? in_imm : in_rs2_value);
        mq.push_back(e);
      end
    end
  end

  task automatic set_uop(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic s1, input logic s2,
                         input logic [4:0] rob, input logic [5:0] phy, input logic [4:0] arch);
    in_fu_opcode = op;  in_rs1_value = rs1; in_rs2_value = rs2;
    in_imm = imm;       in_pc = 32'h1000;   in_op1_sel = s1; in_op2_sel = s2;
    in_rob_id = rob;    in_rd_phy = phy;    in_rd_arch = arch;
  endtask

  // Offers a uop until accepted; returns one step after the transfer edge.
  task automatic send(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] imm, input logic s1, input logic s2,
                      input logic [4:0] rob, input logic [5:0] phy, input logic [4:0] arch);
    logic acc;
    set_uop(op, rs1, rs2, imm, s1, s2, rob, phy, arch);
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) return;
    end
    n_vec++; n_bad++;
    $display("FAIL send_timeout: uop rob %0d not accepted within 50 cycles", rob);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, last_rdy;
    rst = 1'b1; in_valid = 1'b0; cdb_ready = 1'b1;
    set_uop(4'd0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("rst_bypass_valid", 32'(bypass_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Single ADD: latency and payload
    send(4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 5'd3, 6'd9, 5'd1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("add_not_yet", 32'(cdb_valid), 32'd0);
    @(negedge clk);
    chk("add_valid", 32'(cdb_valid), 32'd1);
    chk("add_value", cdb_rd_value, 32'd12);
    chk("add_rob", 32'(cdb_rob_id), 32'd3);
    chk("add_phy", 32'(cdb_rd_phy), 32'd9);
    chk("add_byp_valid", 32'(bypass_valid), 32'd1);
    chk("add_byp_value", bypass_value, 32'd12);
    repeat (2) @(posedge clk); #1;

    // Back-to-back SUB / SRA / SLTU
    seen_val.delete(); seen_cyc.delete();
    send(4'd1, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 5'd4, 6'd10, 5'd2);
    send(4'd7, 32'h8000_0000, 32'd0, 32'd4, 1'b0, 1'b1, 5'd5, 6'd11, 5'd3);
    send(4'd4, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 5'd6, 6'd12, 5'd4);
    in_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    if (seen_val.size() < 3) begin
      n_vec++; n_bad++;
      $display("FAIL b2b_count: got %0d results expected 3", seen_val.size());
    end else begin
      chk("b2b_sub", seen_val[0], 32'hFFFF_FFFE);
      chk("b2b_sra", seen_val[1], 32'hF800_0000);
      chk("b2b_sltu", seen_val[2], 32'd1);
      chk("b2b_consec1", 32'(seen_cyc[1] - seen_cyc[0]), 32'd1);
      chk("b2b_consec2", 32'(seen_cyc[2] - seen_cyc[1]), 32'd1);
    end

    // Stall: 3 uops offered during 4 cycles of cdb_ready=0
    seen_val.delete(); seen_cyc.delete();
    cdb_ready = 1'b0;
    set_uop(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 5'd7, 6'd13, 5'd5);
    in_valid = 1'b1;
    k = 0; last_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      last_rdy = int'(in_ready);
      if (in_ready) k++;
      @(posedge clk); #1;
      if (last_rdy != 0 && k == 1) set_uop(4'd5, 32'hF0, 32'hFF, 32'd0, 1'b0, 1'b0, 5'd8, 6'd14, 5'd6);
      if (last_rdy != 0 && k == 2) set_uop(4'd8, 32'h100, 32'h1, 32'd0, 1'b0, 1'b0, 5'd9, 6'd15, 5'd7);
    end
    chk("stall_accepted", 32'(k), 32'd2);
    chk("stall_in_ready", 32'(last_rdy), 32'd0);
    cdb_ready = 1'b1;
    send(4'd8, 32'h100, 32'h1, 32'd0, 1'b0, 1'b0, 5'd9, 6'd15, 5'd7);
    in_valid = 1'b0;
    repeat (5) @(posedge clk); #1;
    if (seen_val.size() != 3) begin
      n_vec++; n_bad++;
      $display("FAIL stall_count: got %0d results expected 3", seen_val.size());
    end else begin
      chk("stall_r0", seen_val[0], 32'd2);
      chk("stall_r1", seen_val[1], 32'h0F);
      chk("stall_r2", seen_val[2], 32'h101);
    end

    // PASSB to x0
    send(4'd10, 32'h1234, 32'h5678, 32'hABCD_0000, 1'b0, 1'b1, 5'd10, 6'd20, 5'd0);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("x0_valid", 32'(cdb_valid), 32'd1);
    chk("x0_value", cdb_rd_value, 32'd0);
    chk("x0_bypass", 32'(bypass_valid), 32'd0);
    repeat (2) @(posedge clk); #1;

    // Reset with X and W both occupied and CDB stalled
    cdb_ready = 1'b0;
    send(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 5'd11, 6'd21, 5'd1);
    send(4'd0, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 5'd12, 6'd22, 5'd2);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_bypass", 32'(bypass_valid), 32'd0);
    cdb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_stale", 32'(cdb_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] r1, r2;
      r1 = ($urandom % 4 == 0) ? 32'h8000_0000 : $urandom;
      r2 = ($urandom % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
      set_uop(4'($urandom_range(0, 10)), r1, r2, $urandom, 1'($urandom), 1'($urandom),
              5'($urandom), 6'($urandom), ($urandom % 5 == 0) ? 5'd0 : 5'($urandom));
      in_valid  = ($urandom % 4) != 0;
      cdb_ready = ($urandom % 3) != 0;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    cdb_ready = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("drain_empty", 32'(mq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
